// File: rtl/approx_error_monitor.sv
// ============================================================================
// Module      : approx_error_monitor
// Description : Windowed error-statistics collector for an exact/approximate
//               adder pair. Accumulates a saturating error sum, the maximum
//               error, and counts of mismatching and large-error samples.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module approx_error_monitor #(
  parameter int          WINDOW     = 256,
  parameter int          SUM_WIDTH  = 48,
  parameter logic [31:0] ERR_THRESH = 32'h0000_1000
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         sample_valid,
  input  logic [31:0]                  exact_sum,
  input  logic [31:0]                  approx_sum,
  output logic                         busy,
  output logic                         done,
  output logic [SUM_WIDTH-1:0]         err_sum,
  output logic [31:0]                  err_max,
  output logic [$clog2(WINDOW+1)-1:0]  mismatch_cnt,
  output logic [$clog2(WINDOW+1)-1:0]  large_cnt
);

  localparam int CW = $clog2(WINDOW + 1);
  // Adder width leaves at least one carry bit above the accumulator so
  // saturation can be detected even when SUM_WIDTH is narrower than 32.
  localparam int AW = ((SUM_WIDTH > 32) ? SUM_WIDTH : 32) + 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

  state_t          state;
  state_t          state_next;
  logic [CW-1:0]   sample_cnt;
  logic            accept;
  logic            start_ok;
  logic            last_sample;
  logic [31:0]     abs_err;
  logic            s1_valid;
  logic [31:0]     s1_err;
  logic [AW-1:0]   sum_wide;
  logic            sum_ovf;
  logic            done_q;

  // Sample acceptance, window-end detection and absolute error
  always_comb begin
    accept      = (state == COLLECT) && sample_valid;
    start_ok    = start && ((state == IDLE) || (state == DONE));
    last_sample = accept && (sample_cnt == CW'(WINDOW - 1));
    abs_err     = (exact_sum >= approx_sum) ? (exact_sum - approx_sum)
                                            : (approx_sum - exact_sum);
    sum_wide    = AW'(err_sum) + AW'(s1_err);
    sum_ovf     = |sum_wide[AW-1:SUM_WIDTH];
  end

  // Next-state logic and status outputs
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = done_q;
    case (state)
      IDLE:    if (start) state_next = COLLECT;
      COLLECT: begin
        busy = 1'b1;
        if (last_sample) state_next = DRAIN;
      end
      DRAIN: begin
        busy       = 1'b1;
        state_next = DONE;
      end
      DONE:    if (start) state_next = COLLECT;
      default: state_next = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // done is high only in the first DONE cycle, i.e. the cycle after DRAIN
  always_ff @(posedge clk) begin
    if (reset) done_q <= 1'b0;
    else       done_q <= (state == DRAIN);
  end

  // Count accepted samples within the current window
  always_ff @(posedge clk) begin
    if (reset || start_ok) sample_cnt <= '0;
    else if (accept)       sample_cnt <= sample_cnt + CW'(1);
  end

  // Stage 1: register the absolute error of each accepted sample
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      s1_valid <= 1'b0;
      s1_err   <= '0;
    end else begin
      s1_valid <= accept;
      if (accept) s1_err <= abs_err;
    end
  end

  // Stage 2: fold the stage-1 error into the window statistics
  always_ff @(posedge clk) begin
    if (reset || start_ok) begin
      err_sum      <= '0;
      err_max      <= '0;
      mismatch_cnt <= '0;
      large_cnt    <= '0;
    end else if (s1_valid) begin
      err_sum <= sum_ovf ? {SUM_WIDTH{1'b1}} : sum_wide[SUM_WIDTH-1:0];
      if (s1_err > err_max)    err_max      <= s1_err;
      if (s1_err != 32'd0)     mismatch_cnt <= mismatch_cnt + CW'(1);
      if (s1_err > ERR_THRESH) large_cnt    <= large_cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_approx_error_monitor.sv
// ============================================================================
// Module      : tb_approx_error_monitor
// Description : Directed bench for approx_error_monitor with WINDOW=4; one
//               instance with a 48-bit and one with a 33-bit error sum share
//               the stimulus. Expected window results go through a queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_approx_error_monitor;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        sample_valid;
  logic [31:0] exact_sum;
  logic [31:0] approx_sum;

  logic        busy_a, done_a, busy_b, done_b;
  logic [47:0] sum_a;
  logic [32:0] sum_b;
  logic [31:0] max_a, max_b;
  logic [2:0]  mis_a, lg_a, mis_b, lg_b;

  typedef struct {
    logic [63:0] s48;
    logic [63:0] s33;
    logic [31:0] mx;
    int          mis;
    int          lg;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad   = 0;

  logic [63:0] m48, m33;
  logic [31:0] mmax;
  int          mmis, mlg;

  always #5 clk = ~clk;

  approx_error_monitor #(.WINDOW(4), .SUM_WIDTH(48), .ERR_THRESH(32'h0000_1000)) dut_a (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .exact_sum(exact_sum), .approx_sum(approx_sum),
    .busy(busy_a), .done(done_a), .err_sum(sum_a), .err_max(max_a),
    .mismatch_cnt(mis_a), .large_cnt(lg_a)
  );

  approx_error_monitor #(.WINDOW(4), .SUM_WIDTH(33), .ERR_THRESH(32'h0000_1000)) dut_b (
    .clk(clk), .reset(reset), .start(start), .sample_valid(sample_valid),
    .exact_sum(exact_sum), .approx_sum(approx_sum),
    .busy(busy_b), .done(done_b), .err_sum(sum_b), .err_max(max_b),
    .mismatch_cnt(mis_b), .large_cnt(lg_b)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    m48 = 0; m33 = 0; mmax = 0; mmis = 0; mlg = 0;
  endtask

  task automatic model_add(input logic [31:0] ex, input logic [31:0] ap);
    logic [31:0] e;
    e = (ex >= ap) ? ex - ap : ap - ex;
    m48 = m48 + 64'(e);
    if (m48 > 64'hFFFF_FFFF_FFFF) m48 = 64'hFFFF_FFFF_FFFF;
    m33 = m33 + 64'(e);
    if (m33 > 64'h1_FFFF_FFFF) m33 = 64'h1_FFFF_FFFF;
    if (e > mmax) mmax = e;
    if (e != 0) mmis++;
    if (e > 32'h0000_1000) mlg++;
  endtask

  task automatic push_expected();
    exp_t e;
    e.s48 = m48; e.s33 = m33; e.mx = mmax; e.mis = mmis; e.lg = mlg;
    sb.push_back(e);
  endtask

  task automatic send(input logic [31:0] ex, input logic [31:0] ap, input bit counted);
    exact_sum = ex; approx_sum = ap; sample_valid = 1'b1;
    tick();
    sample_valid = 1'b0;
    if (counted) model_add(ex, ap);
  endtask

  task automatic do_start(input bit with_sample);
    start = 1'b1; sample_valid = with_sample;
    exact_sum = 32'd1000; approx_sum = 32'd0;
    tick();
    start = 1'b0; sample_valid = 1'b0;
    model_clear();
    check("busy_after_start", 64'(busy_a), 64'd1);
  endtask

  // Called right after the final sample's edge: the DUT should be in DRAIN
  task automatic finish_window(input bit drain_junk, input bit start_in_done);
    exp_t e;
    check("drain_busy", 64'(busy_a), 64'd1);
    check("drain_done", 64'(done_a), 64'd0);
    sample_valid = drain_junk; exact_sum = 32'h00FF_0000; approx_sum = 32'd0;
    tick();
    sample_valid = 1'b0;
    check("done_pulse", 64'(done_a), 64'd1);
    check("done_pulse_b", 64'(done_b), 64'd1);
    check("done_busy", 64'(busy_a), 64'd0);
    check("sb_nonempty", 64'(sb.size() > 0), 64'd1);
    if (sb.size() == 0) return;
    e = sb.pop_front();
    check("err_sum48", 64'(sum_a), e.s48);
    check("err_sum33", 64'(sum_b), e.s33);
    check("err_max", 64'(max_a), 64'(e.mx));
    check("err_max_b", 64'(max_b), 64'(e.mx));
    check("mismatch_cnt", 64'(mis_a), 64'(e.mis));
    check("large_cnt", 64'(lg_a), 64'(e.lg));
    check("large_cnt_b", 64'(lg_b), 64'(e.lg));
    if (start_in_done) begin
      start = 1'b1; sample_valid = 1'b1;
      tick();
      start = 1'b0; sample_valid = 1'b0;
      model_clear();
      check("restart_busy", 64'(busy_a), 64'd1);
      check("restart_done", 64'(done_a), 64'd0);
      check("restart_sum", 64'(sum_a), 64'd0);
      check("restart_max", 64'(max_a), 64'd0);
      check("restart_mis", 64'(mis_a), 64'd0);
      check("restart_large", 64'(lg_a), 64'd0);
    end else begin
      sample_valid = 1'b1;
      tick();
      sample_valid = 1'b0;
      check("hold_done_low", 64'(done_a), 64'd0);
      check("hold_busy", 64'(busy_a), 64'd0);
      check("hold_sum", 64'(sum_a), e.s48);
      check("hold_mis", 64'(mis_a), 64'(e.mis));
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1; start = 1'b0; sample_valid = 1'b0;
    exact_sum = '0; approx_sum = '0;
    model_clear();
    tick(); tick();
    check("rst_busy", 64'(busy_a), 64'd0);
    check("rst_done", 64'(done_a), 64'd0);
    check("rst_sum", 64'(sum_a), 64'd0);
    check("rst_max", 64'(max_a), 64'd0);
    check("rst_mis", 64'(mis_a), 64'd0);
    check("rst_large", 64'(lg_a), 64'd0);
    reset = 1'b0;
    tick();

    // Exact match window
    do_start(1'b0);
    for (int i = 0; i < 4; i++) send(32'h1234_5678, 32'h1234_5678, 1'b1);
    push_expected();
    finish_window(1'b0, 1'b0);

    // Mixed errors with a gap; sign of the difference is irrelevant
    do_start(1'b0);
    send(32'd100, 32'd90, 1'b1);
    send(32'd90, 32'd100, 1'b1);
    tick();
    check("gap_busy", 64'(busy_a), 64'd1);
    send(32'd5000, 32'd0, 1'b1);
    send(32'd7, 32'd7, 1'b1);
    push_expected();
    check("model_mixed_sum", m48, 64'd5020);
    finish_window(1'b0, 1'b0);

    // Samples in the start cycle and DRAIN/DONE dropped; start in COLLECT ignored
    do_start(1'b1);
    send(32'd3, 32'd1, 1'b1);
    send(32'd1, 32'd3, 1'b1);
    start = 1'b1; exact_sum = 32'd10; approx_sum = 32'd0; sample_valid = 1'b1;
    tick();
    start = 1'b0; sample_valid = 1'b0;
    model_add(32'd10, 32'd0);
    check("start_in_collect_busy", 64'(busy_a), 64'd1);
    send(32'd0, 32'd0, 1'b1);
    push_expected();
    finish_window(1'b1, 1'b0);

    // Saturation of the 33-bit accumulator
    do_start(1'b0);
    for (int i = 0; i < 4; i++) send(32'hFFFF_FFFF, 32'd0, 1'b1);
    push_expected();
    finish_window(1'b0, 1'b0);

    // Reset in the middle of a window
    do_start(1'b0);
    send(32'd50, 32'd0, 1'b1);
    send(32'd50, 32'd0, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midrst_busy", 64'(busy_a), 64'd0);
    check("midrst_done", 64'(done_a), 64'd0);
    check("midrst_sum", 64'(sum_a), 64'd0);
    check("midrst_max", 64'(max_a), 64'd0);
    check("midrst_mis", 64'(mis_a), 64'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("midrst_no_done", 64'(done_a), 64'd0);
      check("midrst_idle", 64'(busy_a), 64'd0);
    end
    do_start(1'b0);
    for (int i = 0; i < 4; i++) send(32'd1, 32'd2, 1'b1);
    push_expected();
    finish_window(1'b0, 1'b0);

    // Back-to-back windows, restart issued in the done cycle
    do_start(1'b0);
    for (int i = 0; i < 4; i++) send(32'd8, 32'd0, 1'b1);
    push_expected();
    finish_window(1'b0, 1'b1);
    send(32'd0, 32'd4096, 1'b1);
    send(32'd4097, 32'd0, 1'b1);
    send(32'd5, 32'd5, 1'b1);
    send(32'd5, 32'd5, 1'b1);
    push_expected();
    finish_window(1'b0, 1'b0);

    check("sb_drained", 64'(sb.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
